// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of a shared tristate bus with turnaround and hold timeout
// Ports: clock/reset (sync, active-high); request[NUM_REQ] per-requester bus request;
// grant/drive[NUM_REQ] registered one-hot ownership and tristate enables (identical);
// owner_id binary owner index (0 when idle); bus_busy high while granted;
// timeout_error one-cycle pulse in the turnaround following a forced revoke.
module bus_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 2,
  parameter int TIMEOUT   = 15,
  parameter int CNT_WIDTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  request,
  output logic [NUM_REQ-1:0]  grant,
  output logic [NUM_REQ-1:0]  drive,
  output logic [ID_WIDTH-1:0] owner_id,
  output logic                bus_busy,
  output logic                timeout_error
);
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;
  state_t state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [ID_WIDTH-1:0] id_n, last, last_n, win;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic to_n, held;
  // Winner is the set request with the smallest rotational distance past last_owner,
  // so last_owner itself sits at the largest distance and is scanned last.
  always_comb begin : pick
    int best;
    int d;
    best = NUM_REQ;
    d = 0;
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = (i + 2 * NUM_REQ - int'(last) - 1) % NUM_REQ;
      if (request[i] && d < best) begin
        best = d;
        win = ID_WIDTH'(i);
      end
    end
  end
  assign held = |(request & grant);
  always_comb begin
    state_n = state;
    grant_n = grant;
    id_n = owner_id;
    cnt_n = cnt;
    last_n = last;
    to_n = 1'b0;
    if (state == IDLE) begin
      if (|request) begin
        state_n = GRANT;
        grant_n = NUM_REQ'(1) << win;
        id_n = win;
        cnt_n = CNT_WIDTH'(1);
        last_n = win;
      end
    end else if (state == GRANT) begin
      // A drop on the timeout cycle is an ordinary release, hence to_n follows held.
      if (!held || cnt == CNT_WIDTH'(TIMEOUT)) begin
        state_n = TURN;
        grant_n = '0;
        id_n = '0;
        cnt_n = '0;
        to_n = held;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end else begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      owner_id <= '0;
      cnt <= '0;
      last <= ID_WIDTH'(NUM_REQ - 1);
      timeout_error <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      owner_id <= id_n;
      cnt <= cnt_n;
      last <= last_n;
      timeout_error <= to_n;
    end
  end
  assign drive = grant;
  assign bus_busy = state == GRANT;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized checks of bus_arbiter against a behavioural model
module tb_bus_arbiter;
  localparam int N = 4;
  localparam int TO = 15;
  logic clock, reset;
  logic [N-1:0] request, grant, drive;
  logic [1:0] owner_id;
  logic bus_busy, timeout_error;
  int total = 0, bad = 0;
  bus_arbiter #(.NUM_REQ(N), .ID_WIDTH(2), .TIMEOUT(TO), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .request(request), .grant(grant), .drive(drive),
    .owner_id(owner_id), .bus_busy(bus_busy), .timeout_error(timeout_error)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  // Model: phase 0 = bus free, 1 = owned (m_hold = cycles owned so far), 2 = dead cycle.
  int m_phase = 0, m_owner = 0, m_hold = 0, m_last = N - 1;
  bit m_to = 0;
  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0; m_owner = 0; m_hold = 0; m_last = N - 1; m_to = 0;
    end else if (m_phase == 0) begin
      m_to = 0;
      if (request != 0) begin
        bit found;
        found = 0;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (!found && request[c]) begin found = 1; m_owner = c; end
        end
        m_last = m_owner; m_hold = 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (!request[m_owner]) begin m_phase = 2; m_to = 0; end
      else if (m_hold == TO) begin m_phase = 2; m_to = 1; end
      else m_hold++;
    end else begin
      m_phase = 0; m_to = 0;
    end
  end
  always @(negedge clock) begin
    logic [N-1:0] eg;
    eg = (m_phase == 1) ? N'(1) << m_owner : '0;
    check("m_grant", grant, eg);
    check("m_drive", drive, eg);
    check("m_owner_id", owner_id, (m_phase == 1) ? m_owner : 0);
    check("m_busy", bus_busy, m_phase == 1);
    check("m_timeout", timeout_error, m_to);
    check("onehot_drive", $countones(drive) <= 1, 1);
  end
  task automatic tick;
    @(negedge clock);
  endtask
  task automatic do_reset;
    reset = 1'b1; request = '0; tick; reset = 1'b0;
  endtask
  initial begin
    int n;
    reset = 1'b1; request = '0;
    tick; tick;
    check("rst_grant", grant, 0); check("rst_drive", drive, 0);
    check("rst_id", owner_id, 0); check("rst_busy", bus_busy, 0); check("rst_to", timeout_error, 0);
    reset = 1'b0; request = 4'b0001;
    tick; check("t1_grant", grant, 4'b0001); check("t1_id", owner_id, 0); check("t1_busy", bus_busy, 1);
    tick; check("t1_grant2", grant, 4'b0001);
    tick; check("t1_grant3", grant, 4'b0001); request = '0;
    tick; check("t1_turn", drive, 0); check("t1_turn_busy", bus_busy, 0);
    tick; check("t1_idle", drive, 0);
    do_reset; request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] e;
      e = N'(1) << (k % N);
      tick; check("t2_rr_a", grant, e);
      tick; check("t2_rr_b", grant, e); request[k % N] = 1'b0;
      tick; check("t2_gap1", drive, 0); request = 4'b1111;
      tick; check("t2_gap2", drive, 0);
    end
    do_reset; request = 4'b0100;
    tick; n = 0;
    while (grant == 4'b0100 && n < 40) begin n++; tick; end
    check("t3_len", n, TO); check("t3_to", timeout_error, 1); check("t3_drive", drive, 0);
    tick; check("t3_idle", drive, 0); check("t3_to_clear", timeout_error, 0);
    tick; check("t3_regrant", grant, 4'b0100);
    do_reset; request = 4'b0100;
    tick; check("t4_own", grant, 4'b0100); request = 4'b0110;
    tick; check("t4_nopre", grant, 4'b0100);
    tick; check("t4_nopre2", grant, 4'b0100); request = 4'b0010;
    tick; check("t4_turn", grant, 0);
    tick; check("t4_idle", grant, 0);
    tick; check("t4_next", grant, 4'b0010);
    do_reset; request = 4'b1000;
    tick; check("t5_own", grant, 4'b1000); check("t5_id", owner_id, 3);
    reset = 1'b1; request = 4'b1001;
    tick; check("t5_grant", grant, 0); check("t5_id0", owner_id, 0); check("t5_busy", bus_busy, 0);
    reset = 1'b0;
    tick; check("t5_ptr", grant, 4'b0001);
    do_reset; request = 4'b0010;
    tick;
    for (int i = 1; i < TO; i++) tick;
    check("t6_hold15", grant, 4'b0010); request = '0;
    tick; check("t6_rel", grant, 0); check("t6_to", timeout_error, 0);
    tick; check("t6_to2", timeout_error, 0);
    do_reset;
    repeat (3000) begin
      logic [N-1:0] nr;
      nr = request;
      for (int b = 0; b < N; b++) begin
        if (m_phase == 1 && b == m_owner) begin
          if ($urandom_range(7) == 0) nr[b] = 1'b0;
        end else if ($urandom_range(3) == 0) nr[b] = ~nr[b];
      end
      request = nr;
      reset = $urandom_range(199) == 0;
      tick;
    end
    reset = 1'b0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
